// File: rtl/iir_df1_biquad_axis.sv
// -----------------------------------------------------------------------------
// iir_df1_biquad_axis
//
// One second-order IIR section (biquad), Direct Form I, fixed integer
// coefficients scaled by 2^scale_factor:
//
//   acc  = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
//   y[n] = sat(acc >>> scale_factor)
//
// The saturated y[n] is what feeds back as y[n-1].
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous reset, ACTIVE HIGH (historic name kept)
//   s_axis_tvalid  input sample valid
//   s_axis_tdata   signed input sample x[n]
//   s_axis_tready  block can accept a sample
//   m_axis_tdata   signed filtered sample y[n]
//   m_axis_tvalid  output sample valid
//   m_axis_tready  downstream ready
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. On the input side tready is low for the 3 cycles the
// pipeline is busy; tvalid is ignored while tready is low (nothing is queued).
// On the output side tvalid/tdata hold until an edge with tready=1, except
// that a freshly computed result replaces an unread one (latest wins). The
// filter never stalls on output backpressure.
//
// Pipeline, acceptance at edge E:
//   E   capture x[n]
//   E+1 register the five products
//   E+2 sum, shift, saturate; advance the x and y delay lines
//   E+3 load the output register (m_axis_tvalid rises)
// -----------------------------------------------------------------------------
module iir_df1_biquad_axis #(
    parameter int coeff_width  = 16,
    parameter int inout_width  = 16,
    parameter int scale_factor = 14,
    parameter int b0_int_coeff = 2962,
    parameter int b1_int_coeff = 5615,
    parameter int b2_int_coeff = 2962,
    parameter int a1_int_coeff = -9362,
    parameter int a2_int_coeff = 5203
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_axis_tvalid,
    input  logic [inout_width-1:0] s_axis_tdata,
    output logic                   s_axis_tready,
    output logic [inout_width-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    localparam int PW = coeff_width + inout_width;  // full product width
    localparam int AW = PW + 3;                     // accumulator with guard bits

    localparam logic signed [coeff_width-1:0] B0 = coeff_width'(b0_int_coeff);
    localparam logic signed [coeff_width-1:0] B1 = coeff_width'(b1_int_coeff);
    localparam logic signed [coeff_width-1:0] B2 = coeff_width'(b2_int_coeff);
    localparam logic signed [coeff_width-1:0] A1 = coeff_width'(a1_int_coeff);
    localparam logic signed [coeff_width-1:0] A2 = coeff_width'(a2_int_coeff);

    // Output range limits, expressed at accumulator width for the compare.
    localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (inout_width - 1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    // Stage occupancy flags: one bit per busy pipeline step.
    logic v0_q, v1_q, v2_q;

    logic signed [inout_width-1:0] x0_q, x1_q, x2_q;
    logic signed [inout_width-1:0] y1_q, y2_q;

    logic signed [PW-1:0] p0_q, p1_q, p2_q, p3_q, p4_q;
    logic signed [PW-1:0] p0_d, p1_d, p2_d, p3_d, p4_d;

    logic signed [AW-1:0]          acc_d;
    logic signed [AW-1:0]          shifted_d;
    logic signed [inout_width-1:0] y_d;

    logic [inout_width-1:0] m_data_q;
    logic                   m_valid_q;
    logic                   accept;

    assign s_axis_tready = ~(v0_q | v1_q | v2_q);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;

    // Products are formed at full width so no product can wrap.
    always_comb begin
        p0_d = PW'(x0_q) * PW'(B0);
        p1_d = PW'(x1_q) * PW'(B1);
        p2_d = PW'(x2_q) * PW'(B2);
        p3_d = PW'(y1_q) * PW'(A1);
        p4_d = PW'(y2_q) * PW'(A2);
    end

    // Sum, floor-shift and saturate. The size casts sign-extend the signed
    // products into the guarded accumulator width.
    always_comb begin
        acc_d     = AW'(p0_q) + AW'(p1_q) + AW'(p2_q) - AW'(p3_q) - AW'(p4_q);
        shifted_d = acc_d >>> scale_factor;
        if (shifted_d > SAT_MAX) begin
            y_d = SAT_MAX[inout_width-1:0];
        end else if (shifted_d < SAT_MIN) begin
            y_d = SAT_MIN[inout_width-1:0];
        end else begin
            y_d = shifted_d[inout_width-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            p0_q      <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            p3_q      <= '0;
            p4_q      <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            v0_q <= accept;
            v1_q <= v0_q;
            v2_q <= v1_q;

            if (accept) begin
                x0_q <= s_axis_tdata;
            end

            if (v0_q) begin
                p0_q <= p0_d;
                p1_q <= p1_d;
                p2_q <= p2_d;
                p3_q <= p3_d;
                p4_q <= p4_d;
            end

            // x0_q still holds x[n] here since no new sample can be accepted
            // until the pipeline drains.
            if (v1_q) begin
                x2_q <= x1_q;
                x1_q <= x0_q;
                y2_q <= y1_q;
                y1_q <= y_d;
            end

            // A new result always wins over an unread one.
            if (v2_q) begin
                m_data_q  <= y1_q;
                m_valid_q <= 1'b1;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iir_df1_biquad_axis.sv
// -----------------------------------------------------------------------------
// tb_iir_df1_biquad_axis
//
// Bench for iir_df1_biquad_axis: default-coefficient instance driven through
// reset, impulse, DC, backpressured noisy sine, random and back-to-back
// phases; a second instance with b0=32767 (others 0) exercises saturation.
// Expected outputs come from a plain-arithmetic filter model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iir_df1_biquad_axis;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;   // 50 MHz

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic         s_tvalid = 1'b0;
    logic [W-1:0] s_tdata  = '0;
    logic         s_tready;
    logic [W-1:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;

    logic         sat_tvalid = 1'b0;
    logic [W-1:0] sat_tdata  = '0;
    logic         sat_tready;
    logic [W-1:0] sat_mdata;
    logic         sat_mvalid;

    iir_df1_biquad_axis u_dut (
        .clk           (clk),
        .rst_n         (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    iir_df1_biquad_axis #(
        .b0_int_coeff (32767),
        .b1_int_coeff (0),
        .b2_int_coeff (0),
        .a1_int_coeff (0),
        .a2_int_coeff (0)
    ) u_sat (
        .clk           (clk),
        .rst_n         (rst),
        .s_axis_tvalid (sat_tvalid),
        .s_axis_tdata  (sat_tdata),
        .s_axis_tready (sat_tready),
        .m_axis_tdata  (sat_mdata),
        .m_axis_tvalid (sat_mvalid),
        .m_axis_tready (1'b1)
    );

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask

    // Reference filter: the difference equation evaluated with 64-bit
    // integers, floor division by 2^14, then clamping to 16-bit range.
    function automatic longint biquad_ref(input longint b0, b1, b2, a1, a2,
                                          input longint x0, x1, x2, y1, y2);
        longint acc;
        longint y;
        acc = b0 * x0 + b1 * x1 + b2 * x2 - a1 * y1 - a2 * y2;
        y = acc >>> 14;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];   // model results in acceptance order
    int           due_q[$];   // edge count after which each result is visible
    logic [W-1:0] out_log[$]; // values actually taken by downstream
    longint mx1, mx2, my1, my2;
    longint mx, my;
    bit     mon_en   = 1'b0;
    bit     b2b_mode = 1'b0;
    int     last_acc = -1;
    int     n_acc    = 0;
    int     n_avail;

    always @(negedge clk) begin
        if (mon_en) begin
            // Output side: the newest result visible by now must be presented.
            n_avail = 0;
            foreach (due_q[i]) if (due_q[i] <= cyc) n_avail = i + 1;
            if (n_avail > 0) begin
                chk("m_tvalid", m_tvalid, 1);
                chk("m_tdata", $signed(m_tdata), $signed(exp_q[n_avail-1]));
                if (m_tready) begin
                    if (m_tvalid) out_log.push_back(m_tdata);
                    repeat (n_avail) begin
                        void'(exp_q.pop_front());
                        void'(due_q.pop_front());
                    end
                end
            end else begin
                chk("m_tvalid_idle", m_tvalid, 0);
            end

            // Input side: an acceptance happens on the coming rising edge.
            if (s_tvalid && s_tready) begin
                mx = $signed(s_tdata);
                my = biquad_ref(2962, 5615, 2962, -9362, 5203, mx, mx1, mx2, my1, my2);
                mx2 = mx1; mx1 = mx; my2 = my1; my1 = my;
                exp_q.push_back(W'(my));
                due_q.push_back(cyc + 4);
                n_acc++;
                if (b2b_mode && last_acc >= 0) chk("accept_gap", cyc - last_acc, 4);
                last_acc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        mon_en     = 1'b0;
        rst        = 1'b1;
        s_tvalid   = 1'b0;
        sat_tvalid = 1'b0;
        exp_q.delete();
        due_q.delete();
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", s_tready, 1);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    // Present x and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_sample(input logic [W-1:0] x);
        int t;
        t = 0;
        s_tdata  = x;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!s_tready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic sat_send(input logic [W-1:0] x);
        int     t;
        longint y;
        t = 0;
        sat_tdata  = x;
        sat_tvalid = 1'b1;
        @(negedge clk);
        while (!sat_tready && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        sat_tvalid = 1'b0;
        y = biquad_ref(32767, 0, 0, 0, 0, $signed(x), 0, 0, 0, 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!sat_mvalid && t < 10);
        chk("sat_valid", sat_mvalid, 1);
        chk("sat_data", $signed(sat_mdata), y);
    endtask

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int     xi;
        int     seen;
        longint last;

        // Reset state and post-release state
        apply_reset();
        @(negedge clk);
        chk("post_rst_s_tready", s_tready, 1);
        chk("post_rst_m_tvalid", m_tvalid, 0);
        chk("post_rst_m_tdata", m_tdata, 0);
        idle(1);

        // Reset mid-computation discards the in-flight sample
        send_sample(16'd1234);
        idle(1);
        apply_reset();
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_tvalid) seen = 1;
        end
        chk("rst_discard", seen, 0);
        idle(1);

        // Impulse, one sample every 5 clocks, ready high
        apply_reset();
        out_log.delete();
        m_tready = 1'b1;
        send_sample(16'sd32767);
        idle(4);
        repeat (30) begin
            send_sample('0);
            idle(4);
        end
        idle(6);
        chk("imp_count", out_log.size(), 31);
        if (out_log.size() >= 31) begin
            chk("imp_y0", $signed(out_log[0]), 5923);
            chk("imp_y1", $signed(out_log[1]), 14614);
            chk("imp_y2", $signed(out_log[2]), 12393);
            last = $signed(out_log[30]);
            chk("imp_decay", (last <= 8 && last >= -8), 1);
        end

        // DC input settles at 9438 within 2 LSB
        apply_reset();
        out_log.delete();
        repeat (100) begin
            send_sample(16'sd10000);
            idle(4);
        end
        idle(6);
        chk("dc_count", out_log.size(), 100);
        if (out_log.size() > 0) begin
            last = $signed(out_log[out_log.size()-1]);
            chk("dc_settle", (last >= 9436 && last <= 9440), 1);
        end

        // Noisy 500 kHz sine at 10 MHz sample rate, ~20 samples backpressured
        apply_reset();
        for (int n = 0; n < 100; n++) begin
            xi = int'(20000.0 * $sin(2.0 * 3.14159265358979 * n / 20.0))
                 + int'($urandom_range(0, 2000)) - 1000;
            m_tready = !(n >= 30 && n < 50);
            send_sample(W'(xi));
            idle(4);
        end
        m_tready = 1'b1;
        idle(6);
        chk("sine_drain", exp_q.size(), 0);

        // Random full-range samples, random gaps, random downstream ready
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            m_tready = 1'($urandom_range(0, 1));
            send_sample(W'($urandom_range(0, 65535)));
            idle($urandom_range(3, 8));
        end
        m_tready = 1'b1;
        idle(8);
        chk("rand_drain", exp_q.size(), 0);

        // Back-to-back valid: exactly one acceptance per 4 clocks
        apply_reset();
        n_acc    = 0;
        last_acc = -1;
        b2b_mode = 1'b1;
        s_tvalid = 1'b1;
        repeat (80) begin
            s_tdata = W'($urandom_range(0, 65535));
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        b2b_mode = 1'b0;
        chk("b2b_count", n_acc, 20);
        idle(8);
        chk("b2b_drain", exp_q.size(), 0);

        // Saturation instance
        apply_reset();
        sat_send(16'sd32767);
        sat_send(16'h8000);
        sat_send(16'sd1000);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/iir_df1_biquad_axis.md
Name: iir_df1_biquad_axis

Overview:
Single second-order IIR section (biquad) in Direct Form I with fixed integer coefficients, using AXI4-Stream slave input and AXI4-Stream master output. It sits in a sample-rate signal path where samples arrive much slower than the clock (e.g. 10 MHz samples on a 50 MHz clock). It accepts one signed sample per handshake and produces one filtered signed sample per accepted input.

Parameters:
coeff_width, 16, signed coefficient width in bits
inout_width, 16, signed input/output sample width in bits
scale_factor, 14, coefficient fractional bits; coefficient value = int/2^scale_factor
b0_int_coeff, 2962, feed-forward x[n] coefficient
b1_int_coeff, 5615, feed-forward x[n-1] coefficient
b2_int_coeff, 2962, feed-forward x[n-2] coefficient
a1_int_coeff, -9362, feedback y[n-1] coefficient (denominator sign convention)
a2_int_coeff, 5203, feedback y[n-2] coefficient (denominator sign convention)

Ports:
clk  in  1  system clock, all logic on the rising edge
rst_n  in  1  reset, asynchronous, active-high. The codebase name is kept; asserting it high resets the block.
s_axis_tvalid  in  1  input sample valid
s_axis_tdata  in  inout_width  signed input sample x[n]
s_axis_tready  out  1  block can accept a sample
m_axis_tdata  out  inout_width  signed output sample y[n]
m_axis_tvalid  out  1  output sample valid
m_axis_tready  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release):
  - x[n-1], x[n-2], y[n-1], y[n-2] and all pipeline registers go to 0.
  - m_axis_tdata=0, m_axis_tvalid=0, s_axis_tready=1.
  - Reset mid-computation discards the in-flight sample.
- Equation: acc = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2].
  - Products are signed, coeff_width+inout_width bits.
  - acc is the product width +3 guard bits; no overflow allowed inside acc.
- Scaling:
  - y[n] = acc arithmetic-shifted right by scale_factor (floor, no rounding).
  - Result then saturates to the signed inout_width range: 16-bit limits are 32767 and -32768.
  - The saturated y[n] is the value fed back as y[n-1].
- Input acceptance:
  - A sample is accepted on a clock edge with s_axis_tvalid=1 and s_axis_tready=1.
  - s_axis_tready drops the cycle after acceptance and stays low for 3 cycles while computing.
  - It returns high on the 4th cycle after acceptance.
  - Maximum throughput is 1 sample per 4 clocks.
  - While tready is low, s_axis_tvalid is ignored; no sample is accepted or queued.
- Pipeline, with acceptance at edge E:
  - E: capture x[n].
  - E+1: form the five products.
  - E+2: sum, shift and saturate; update the delay lines (x[n-2]<=x[n-1], x[n-1]<=x[n], y[n-2]<=y[n-1], y[n-1]<=y[n]).
  - E+3: load the output register.
  - Latency is 3 clocks from the accepting edge to m_axis_tvalid high.
- Output handshake:
  - m_axis_tvalid=1 with m_axis_tdata stable until an edge with m_axis_tready=1; tvalid then clears unless a new result loads on that same edge.
  - With m_axis_tready held high, tvalid is a 1-cycle pulse per sample.
  - There is no FIFO. The filter keeps running while m_axis_tready=0.
  - A new result overwrites a pending unread one (latest wins), and tvalid stays high.
  - When ready returns, the latest result is presented.
- Filter state depends only on accepted inputs, never on output backpressure.

Test Plan:
1. Reset with rst_n=1, then release → s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0. Assert rst_n mid-computation → tvalid never rises for that sample.
2. Impulse at default parameters: 32767, then zeros, one sample every 5 clocks with m_axis_tready=1.
   - Outputs start 5923, 14614, 12393, …, decaying toward 0.
   - Each tvalid pulse comes exactly 3 clocks after acceptance.
3. Constant input 10000 for 100 samples → output settles at 9438 (DC gain 11539/12225), within ±2 LSB.
4. Saturation with b0=32767 and other coefficients 0, one sample at a time:
   - Input 32767 → output 32767.
   - Input -32768 → output -32768.
5. Backpressure: m_axis_tready=0 for roughly 20 samples during a noisy 500 kHz sine at 10 MHz sample rate.
   - tvalid stays high and tdata holds the most recent result.
   - After ready returns, the output matches a golden model run with ready always high, i.e. no state corruption.
6. Back-to-back s_axis_tvalid held high continuously → exactly one acceptance per 4 clocks, no dropped or duplicate outputs.
